data_wb: RTL and testbench

Write-back stage of the pipelined LEGv8 CPU: the writer side of the register-file interface that the decode stage reads. Registers the MEM-stage result into the MEM/WB latch, selects write data (ALU result, load data, or BL link address) and drives the register-file write port. Also bypasses in-flight results to the decode-stage read operands, suppresses duplicate writes while stalled, and counts retired instructions.

---
 rtl/data_wb_if.sv | 40 ++++
 rtl/data_wb.sv | 104 ++++++++++
 tb/tb_data_wb.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_wb_if.sv
// MEM/WB pipeline signals, register-file write port and decode-stage bypass outputs.
// The master drives the MEM stage and the decode read ports; the slave is the write-back stage.
interface data_wb_if;
    logic        mem_valid;
    logic [63:0] mem_alu;
    logic [63:0] mem_rdata;
    logic [63:0] mem_pc;
    logic [4:0]  mem_Rd;
    logic        mem_RegWrite;
    logic        mem_MemtoReg;
    logic        mem_BLsignal;
    logic        stall;
    logic        flush;
    logic [4:0]  id_Rn;
    logic [4:0]  id_Ab;
    logic [63:0] id_Da;
    logic [63:0] id_Db;
    logic [63:0] Dw;
    logic [4:0]  Aw;
    logic        RegWrite;
    logic [63:0] fwd_Da;
    logic [63:0] fwd_Db;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic [63:0] retired;

    modport master (
        output mem_valid, mem_alu, mem_rdata, mem_pc, mem_Rd,
               mem_RegWrite, mem_MemtoReg, mem_BLsignal, stall, flush,
               id_Rn, id_Ab, id_Da, id_Db,
        input  Dw, Aw, RegWrite, fwd_Da, fwd_Db, fwd_a_sel, fwd_b_sel, retired
    );

    modport slave (
        input  mem_valid, mem_alu, mem_rdata, mem_pc, mem_Rd,
               mem_RegWrite, mem_MemtoReg, mem_BLsignal, stall, flush,
               id_Rn, id_Ab, id_Da, id_Db,
        output Dw, Aw, RegWrite, fwd_Da, fwd_Db, fwd_a_sel, fwd_b_sel, retired
    );
endinterface

// File: rtl/data_wb.sv
// LEGv8 write-back stage: MEM/WB latch, register-file write port, decode-stage bypass
// and a retired-instruction counter.
module data_wb #(
    parameter logic [4:0] XZR_IDX  = 5'd31,
    parameter logic [4:0] LINK_IDX = 5'd30
) (
    input logic     clk,
    input logic     reset,
    data_wb_if.slave bus
);

    logic        wb_valid;
    logic [63:0] wb_alu;
    logic [63:0] wb_rdata;
    logic [63:0] wb_pc;
    logic [4:0]  wb_rd;
    logic        wb_regwrite;
    logic        wb_memtoreg;
    logic        wb_bl;
    logic        wb_wrote;
    logic [63:0] retired_q;

    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
    logic        wb_cap;
    logic [4:0]  mem_addr;
    logic [63:0] mem_data;
    logic        mem_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid    <= 1'b0;
            wb_alu      <= '0;
            wb_rdata    <= '0;
            wb_pc       <= '0;
            wb_rd       <= '0;
            wb_regwrite <= 1'b0;
            wb_memtoreg <= 1'b0;
            wb_bl       <= 1'b0;
            wb_wrote    <= 1'b0;
            retired_q   <= '0;
        end else begin
            if (wb_valid && !wb_wrote)
                retired_q <= retired_q + 64'd1;
            if (bus.flush) begin
                wb_valid    <= 1'b0;
                wb_alu      <= '0;
                wb_rdata    <= '0;
                wb_pc       <= '0;
                wb_rd       <= '0;
                wb_regwrite <= 1'b0;
                wb_memtoreg <= 1'b0;
                wb_bl       <= 1'b0;
                wb_wrote    <= 1'b0;
            end else if (bus.stall) begin
                // held entry has already had its write cycle
                wb_wrote <= 1'b1;
            end else begin
                wb_valid    <= bus.mem_valid;
                wb_alu      <= bus.mem_alu;
                wb_rdata    <= bus.mem_rdata;
                wb_pc       <= bus.mem_pc;
                wb_rd       <= bus.mem_Rd;
                wb_regwrite <= bus.mem_RegWrite;
                wb_memtoreg <= bus.mem_MemtoReg;
                wb_bl       <= bus.mem_BLsignal;
                wb_wrote    <= 1'b0;
            end
        end
    end

    always_comb begin
        wb_addr  = wb_bl ? LINK_IDX : wb_rd;
        wb_data  = wb_bl ? (wb_pc + 64'd4) : (wb_memtoreg ? wb_rdata : wb_alu);
        wb_cap   = wb_valid && (wb_regwrite || wb_bl);
        mem_addr = bus.mem_BLsignal ? LINK_IDX : bus.mem_Rd;
        mem_data = bus.mem_BLsignal ? (bus.mem_pc + 64'd4)
                                    : (bus.mem_MemtoReg ? bus.mem_rdata : bus.mem_alu);
        mem_we   = bus.mem_valid && (bus.mem_RegWrite || bus.mem_BLsignal);
    end

    // Returns {sel, data}; the MEM stage is younger than the WB latch so it wins.
    function automatic logic [65:0] bypass(input logic [4:0] addr, input logic [63:0] raw);
        logic [65:0] r;
        r = {2'd0, raw};
        if (addr == XZR_IDX)
            r = {2'd0, raw};
        else if (mem_we && (mem_addr == addr))
            r = {2'd1, mem_data};
        else if (wb_cap && (wb_addr == addr))
            r = {2'd2, wb_data};
        return r;
    endfunction

    always_comb begin
        bus.Dw       = wb_data;
        bus.Aw       = wb_addr;
        bus.RegWrite = wb_cap && !wb_wrote && (wb_addr != XZR_IDX);
        bus.retired  = retired_q;
        {bus.fwd_a_sel, bus.fwd_Da} = bypass(bus.id_Rn, bus.id_Da);
        {bus.fwd_b_sel, bus.fwd_Db} = bypass(bus.id_Ab, bus.id_Db);
    end

endmodule

// File: tb/tb_data_wb.sv
// Randomized bench for data_wb against a transaction-level model of the write-back stage.
module tb_data_wb;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_wb_if bus ();

    data_wb dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic        valid;
        logic [63:0] alu;
        logic [63:0] rdata;
        logic [63:0] pc;
        logic [4:0]  rd;
        logic        rw;
        logic        m2r;
        logic        bl;
        logic        wrote;
    } ent_t;

    ent_t        lat;
    logic [63:0] m_ret;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ent_data(input ent_t e);
        if (e.bl) return e.pc + 64'd4;
        return e.m2r ? e.rdata : e.alu;
    endfunction

    function automatic logic [4:0] ent_addr(input ent_t e);
        return e.bl ? 5'd30 : e.rd;
    endfunction

    function automatic ent_t mem_ent();
        ent_t e;
        e.valid = bus.mem_valid;
        e.alu   = bus.mem_alu;
        e.rdata = bus.mem_rdata;
        e.pc    = bus.mem_pc;
        e.rd    = bus.mem_Rd;
        e.rw    = bus.mem_RegWrite;
        e.m2r   = bus.mem_MemtoReg;
        e.bl    = bus.mem_BLsignal;
        e.wrote = 1'b0;
        return e;
    endfunction

    task automatic fwd_model(input logic [4:0] a, input logic [63:0] raw,
                             output logic [1:0] sel, output logic [63:0] d);
        ent_t me;
        me = mem_ent();
        if (a == 5'd31) begin
            sel = 2'd0; d = raw;
        end else if (me.valid && (me.rw || me.bl) && ent_addr(me) == a) begin
            sel = 2'd1; d = ent_data(me);
        end else if (lat.valid && (lat.rw || lat.bl) && ent_addr(lat) == a) begin
            sel = 2'd2; d = ent_data(lat);
        end else begin
            sel = 2'd0; d = raw;
        end
    endtask

    task automatic check_outputs();
        logic        exp_we;
        logic [1:0]  s;
        logic [63:0] d;
        exp_we = lat.valid && (lat.rw || lat.bl) && !lat.wrote && (ent_addr(lat) != 5'd31);
        check("RegWrite", {63'd0, bus.RegWrite}, {63'd0, exp_we});
        if (lat.valid) begin
            check("Dw", bus.Dw, ent_data(lat));
            check("Aw", {59'd0, bus.Aw}, {59'd0, ent_addr(lat)});
        end
        check("retired", bus.retired, m_ret);
        fwd_model(bus.id_Rn, bus.id_Da, s, d);
        check("fwd_a_sel", {62'd0, bus.fwd_a_sel}, {62'd0, s});
        check("fwd_Da", bus.fwd_Da, d);
        fwd_model(bus.id_Ab, bus.id_Db, s, d);
        check("fwd_b_sel", {62'd0, bus.fwd_b_sel}, {62'd0, s});
        check("fwd_Db", bus.fwd_Db, d);
    endtask

    task automatic clock_model();
        if (reset) begin
            lat   = '0;
            m_ret = '0;
        end else begin
            if (lat.valid && !lat.wrote) m_ret = m_ret + 64'd1;
            if (bus.flush) begin
                lat.valid = 1'b0;
                lat.wrote = 1'b0;
            end else if (bus.stall) begin
                lat.wrote = 1'b1;
            end else begin
                lat = mem_ent();
            end
        end
    endtask

    task automatic step();
        #1;
        check_outputs();
        @(posedge clk);
        clock_model();
        @(negedge clk);
    endtask

    task automatic set_idle();
        bus.mem_valid    = 1'b0;
        bus.mem_alu      = '0;
        bus.mem_rdata    = '0;
        bus.mem_pc       = '0;
        bus.mem_Rd       = '0;
        bus.mem_RegWrite = 1'b0;
        bus.mem_MemtoReg = 1'b0;
        bus.mem_BLsignal = 1'b0;
        bus.stall        = 1'b0;
        bus.flush        = 1'b0;
        bus.id_Rn        = '0;
        bus.id_Ab        = '0;
        bus.id_Da        = '0;
        bus.id_Db        = '0;
    endtask

    task automatic drive(input logic v, input logic [63:0] alu, input logic [63:0] rdata,
                         input logic [63:0] pc, input logic [4:0] rd,
                         input logic rw, input logic m2r, input logic bl);
        bus.mem_valid    = v;
        bus.mem_alu      = alu;
        bus.mem_rdata    = rdata;
        bus.mem_pc       = pc;
        bus.mem_Rd       = rd;
        bus.mem_RegWrite = rw;
        bus.mem_MemtoReg = m2r;
        bus.mem_BLsignal = bl;
    endtask

    function automatic logic [4:0] pick_reg();
        logic [4:0] r;
        r = 5'($urandom_range(0, 9));
        if (r == 5'd8) r = 5'd30;
        if (r == 5'd9) r = 5'd31;
        return r;
    endfunction

    initial begin : stim
        logic [63:0] ret0;
        lat   = '0;
        m_ret = '0;
        set_idle();
        reset = 1'b1;
        bus.mem_valid = 1'b1;
        bus.mem_RegWrite = 1'b1;
        bus.mem_Rd = 5'd3;
        bus.mem_alu = 64'h77;
        repeat (2) begin
            @(posedge clk);
            clock_model();
        end
        @(negedge clk);
        reset = 1'b0;
        set_idle();
        #1;
        check("rst_RegWrite", {63'd0, bus.RegWrite}, 64'd0);
        check("rst_Aw", {59'd0, bus.Aw}, 64'd0);
        check("rst_Dw", bus.Dw, 64'd0);
        check("rst_retired", bus.retired, 64'd0);
        check("rst_fwd_a_sel", {62'd0, bus.fwd_a_sel}, 64'd0);
        step();

        drive(1, 64'h10, 64'hAB, 64'h0, 5'd3, 1, 1, 0);
        step();
        drive(1, 64'h10, 64'hAB, 64'h0, 5'd3, 1, 0, 0);
        #1;
        check("load_Dw", bus.Dw, 64'hAB);
        check("load_Aw", {59'd0, bus.Aw}, 64'd3);
        check("load_RegWrite", {63'd0, bus.RegWrite}, 64'd1);
        step();
        set_idle();
        #1;
        check("alu_Dw", bus.Dw, 64'h10);
        step();

        drive(1, 64'h0, 64'h0, 64'h100, 5'd7, 0, 0, 1);
        step();
        set_idle();
        bus.id_Rn = 5'd30;
        bus.id_Da = 64'hDEAD;
        #1;
        check("bl_Dw", bus.Dw, 64'h104);
        check("bl_Aw", {59'd0, bus.Aw}, 64'd30);
        check("bl_RegWrite", {63'd0, bus.RegWrite}, 64'd1);
        check("bl_fwd_a_sel", {62'd0, bus.fwd_a_sel}, 64'd2);
        check("bl_fwd_Da", bus.fwd_Da, 64'h104);
        step();

        drive(1, 64'h11, 64'h0, 64'h0, 5'd4, 1, 0, 0);
        step();
        drive(1, 64'h22, 64'h0, 64'h0, 5'd4, 1, 0, 0);
        bus.id_Ab = 5'd4;  bus.id_Db = 64'h66;
        bus.id_Rn = 5'd31; bus.id_Da = 64'h55;
        #1;
        check("prio_fwd_b_sel", {62'd0, bus.fwd_b_sel}, 64'd1);
        check("prio_fwd_Db", bus.fwd_Db, 64'h22);
        check("xzr_fwd_a_sel", {62'd0, bus.fwd_a_sel}, 64'd0);
        check("xzr_fwd_Da", bus.fwd_Da, 64'h55);
        step();
        set_idle();
        step();
        step();

        ret0 = m_ret;
        drive(1, 64'h5A5A, 64'h0, 64'h0, 5'd2, 1, 0, 0);
        step();
        drive(1, 64'h999, 64'h0, 64'h0, 5'd6, 1, 0, 0);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_RegWrite", {63'd0, bus.RegWrite}, (i == 0) ? 64'd1 : 64'd0);
            check("stall_Dw", bus.Dw, 64'h5A5A);
            step();
        end
        set_idle();
        #1;
        check("stall_retired", bus.retired, ret0 + 64'd1);
        step();

        ret0 = m_ret;
        drive(1, 64'h33, 64'h0, 64'h0, 5'd5, 1, 0, 0);
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        step();
        set_idle();
        #1;
        check("flush_RegWrite", {63'd0, bus.RegWrite}, 64'd0);
        check("flush_retired", bus.retired, ret0);
        step();

        drive(1, 64'h44, 64'h0, 64'h0, 5'd9, 1, 0, 0);
        step();
        bus.stall = 1'b1;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_idle();
        #1;
        check("midrst_retired", bus.retired, 64'd0);
        check("midrst_RegWrite", {63'd0, bus.RegWrite}, 64'd0);
        step();

        drive(1, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE, 5'd1, 0, 0, 1);
        step();
        set_idle();
        #1;
        check("bl_wrap_Dw", bus.Dw, 64'h2);
        step();

        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 3) != 0, {$urandom, $urandom}, {$urandom, $urandom},
                  ($urandom_range(0, 15) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : {$urandom, $urandom},
                  pick_reg(), 1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0));
            bus.stall = ($urandom_range(0, 4) == 0);
            bus.flush = ($urandom_range(0, 9) == 0);
            bus.id_Rn = pick_reg();
            bus.id_Ab = pick_reg();
            bus.id_Da = {$urandom, $urandom};
            bus.id_Db = {$urandom, $urandom};
            reset     = ($urandom_range(0, 49) == 0);
            step();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
